// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song memory walker driving the Buzzer with timed notes and muted gaps
module note_sequencer #(
   parameter int BEAT_CYCLES = 50000000,
   parameter int GAP_CYCLES  = 10000000,
   parameter int SONG_LEN    = 32,
   parameter int DUR_W       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop_req,
   input  logic             pause,
   input  logic             loop_en,
   output logic [7:0]       mem_addr,
   input  logic [9:0]       mem_data,
   input  logic [DUR_W-1:0] mem_dur,
   output logic [6:0]       note,
   output logic [2:0]       pitch,
   output logic             mute,
   output logic             playing,
   output logic             song_done
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2, PAUSED = 2'd3} state_t;

   localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [7:0]  ADDR_LAST = 8'(SONG_LEN - 1);

   state_t           state;
   state_t           saved;
   logic [31:0]      cyc;
   logic [DUR_W-1:0] beat;
   logic [DUR_W-1:0] dur;

   // Where an un-paused PLAY/GAP cycle would take the sequencer next
   state_t           adv_state;
   logic [31:0]      adv_cyc;
   logic [DUR_W-1:0] adv_beat;
   logic [7:0]       adv_addr;
   logic             adv_load;
   logic             adv_done;
   logic [7:0]       next_addr;
   logic             song_end;

   // One step of playback timing; a paused cycle still advances so sounded time per note is preserved
   always_comb begin
      next_addr = (mem_addr == ADDR_LAST) ? 8'd0 : mem_addr + 8'd1;
      song_end  = (mem_dur == '0) || ((mem_addr == 8'd0) && !loop_en);
      adv_state = state;
      adv_cyc   = cyc + 32'd1;
      adv_beat  = beat;
      adv_addr  = mem_addr;
      adv_load  = 1'b0;
      adv_done  = 1'b0;
      case (state)
         PLAY: begin
            if (cyc == BEAT_LAST) begin
               adv_cyc = '0;
               if (beat == dur - DUR_W'(1)) begin
                  adv_beat  = '0;
                  adv_state = GAP;
                  adv_addr  = next_addr;
               end else begin
                  adv_beat = beat + DUR_W'(1);
               end
            end
         end
         GAP: begin
            if (cyc == GAP_LAST) begin
               adv_cyc  = '0;
               adv_beat = '0;
               if (song_end) begin
                  adv_state = IDLE;
                  adv_addr  = '0;
                  adv_done  = 1'b1;
               end else begin
                  adv_state = PLAY;
                  adv_load  = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencer state machine with registered Buzzer-facing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         saved     <= IDLE;
         cyc       <= '0;
         beat      <= '0;
         dur       <= '0;
         mem_addr  <= '0;
         note      <= '0;
         pitch     <= '0;
         mute      <= 1'b1;
         playing   <= 1'b0;
         song_done <= 1'b0;
      end else begin
         song_done <= 1'b0;
         if (stop_req) begin
            state    <= IDLE;
            saved    <= IDLE;
            mem_addr <= '0;
            mute     <= 1'b1;
            playing  <= 1'b0;
            cyc      <= '0;
            beat     <= '0;
         end else begin
            case (state)
               IDLE: begin
                  mem_addr <= '0;
                  mute     <= 1'b1;
                  playing  <= 1'b0;
                  cyc      <= '0;
                  beat     <= '0;
                  if (start) begin
                     if (mem_dur == '0) begin
                        song_done <= 1'b1;
                     end else begin
                        note    <= mem_data[9:3];
                        pitch   <= mem_data[2:0];
                        dur     <= mem_dur;
                        state   <= PLAY;
                        mute    <= 1'b0;
                        playing <= 1'b1;
                     end
                  end
               end
               PLAY, GAP: begin
                  cyc       <= adv_cyc;
                  beat      <= adv_beat;
                  mem_addr  <= adv_addr;
                  song_done <= adv_done;
                  if (adv_load) begin
                     note  <= mem_data[9:3];
                     pitch <= mem_data[2:0];
                     dur   <= mem_dur;
                  end
                  if (adv_state == IDLE) begin
                     state   <= IDLE;
                     mute    <= 1'b1;
                     playing <= 1'b0;
                  end else if (pause) begin
                     state   <= PAUSED;
                     saved   <= adv_state;
                     mute    <= 1'b1;
                     playing <= 1'b1;
                  end else begin
                     state   <= adv_state;
                     mute    <= (adv_state != PLAY);
                     playing <= 1'b1;
                  end
               end
               PAUSED: begin
                  if (!pause) begin
                     state <= saved;
                     mute  <= (saved != PLAY);
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;
   localparam int BEAT = 10;
   localparam int GAP  = 2;
   localparam int LEN  = 4;
   localparam int DW   = 3;
   localparam int CAP  = 400;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop_req = 1'b0;
   logic          pause = 1'b0;
   logic          loop_en = 1'b0;
   logic [7:0]    mem_addr;
   logic [9:0]    mem_data;
   logic [DW-1:0] mem_dur;
   logic [6:0]    note;
   logic [2:0]    pitch;
   logic          mute;
   logic          playing;
   logic          song_done;

   logic [6:0]    s_note[LEN];
   logic [2:0]    s_pitch[LEN];
   logic [DW-1:0] s_dur[LEN];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       mute;
      logic       playing;
      logic       done;
      logic [7:0] addr;
      logic [6:0] note;
      logic [2:0] pitch;
   } frame_t;

   typedef struct {
      logic       start;
      int         cycles;
      frame_t     exp;
   } vec_t;

   note_sequencer #(
      .BEAT_CYCLES(BEAT),
      .GAP_CYCLES(GAP),
      .SONG_LEN(LEN),
      .DUR_W(DW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stop_req(stop_req),
      .pause(pause),
      .loop_en(loop_en),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_dur(mem_dur),
      .note(note),
      .pitch(pitch),
      .mute(mute),
      .playing(playing),
      .song_done(song_done)
   );

   always #5 clk = ~clk;

   assign mem_data = {s_note[mem_addr[1:0]], s_pitch[mem_addr[1:0]]};
   assign mem_dur  = s_dur[mem_addr[1:0]];

   function automatic frame_t mk(input int m, input int pl, input int d, input int a, input int n, input int p);
      mk = {1'(m), 1'(pl), 1'(d), 8'(a), 7'(n), 3'(p)};
   endfunction

   function automatic frame_t obs();
      obs = {mute, playing, song_done, mem_addr, note, pitch};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_frame(input string nm, input frame_t e);
      chk(nm, 32'(obs()), 32'(e));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start    = 1'b0;
      stop_req = 1'b0;
      pause    = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic set_song(input int d0, input int d1, input int d2, input int d3);
      s_dur[0] = DW'(d0); s_dur[1] = DW'(d1); s_dur[2] = DW'(d2); s_dur[3] = DW'(d3);
      s_note[0] = 7'd11; s_note[1] = 7'd22; s_note[2] = 7'd0; s_note[3] = 7'd44;
      for (int i = 0; i < LEN; i++) s_pitch[i] = 3'(i + 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t   tbl[$];
      frame_t q[$];
      frame_t pf;
      int     done_at, snd, bad, muted, idx, plen, a, na;
      logic   fin;
      logic [6:0] ln;
      logic [2:0] lp;

      set_song(1, 2, 1, 1);
      do_reset();
      chk_frame("reset_state", mk(1, 0, 0, 0, 0, 0));

      // basic play, table-driven
      tbl.push_back('{1'b0, 2,  mk(1, 0, 0, 0, 0, 0)});
      tbl.push_back('{1'b1, 1,  mk(0, 1, 0, 0, 11, 1)});
      tbl.push_back('{1'b0, 9,  mk(0, 1, 0, 0, 11, 1)});
      tbl.push_back('{1'b0, 2,  mk(1, 1, 0, 1, 11, 1)});
      tbl.push_back('{1'b0, 20, mk(0, 1, 0, 1, 22, 2)});
      tbl.push_back('{1'b0, 2,  mk(1, 1, 0, 2, 22, 2)});
      tbl.push_back('{1'b0, 10, mk(0, 1, 0, 2, 0, 3)});
      tbl.push_back('{1'b0, 2,  mk(1, 1, 0, 3, 0, 3)});
      tbl.push_back('{1'b0, 10, mk(0, 1, 0, 3, 44, 4)});
      tbl.push_back('{1'b0, 2,  mk(1, 1, 0, 0, 44, 4)});
      tbl.push_back('{1'b0, 1,  mk(1, 0, 1, 0, 44, 4)});
      tbl.push_back('{1'b0, 3,  mk(1, 0, 0, 0, 44, 4)});
      for (int r = 0; r < tbl.size(); r++) begin
         start = tbl[r].start;
         for (int c = 0; c < tbl[r].cycles; c++) begin
            tick();
            start = 1'b0;
            chk_frame($sformatf("basic_row%0d_cyc%0d", r, c), tbl[r].exp);
         end
      end

      // loop then drop loop_en
      do_reset();
      set_song(1, 2, 1, 1);
      loop_en = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      done_at = 0;
      for (int f = 1; f <= 130; f++) begin
         if (f > 1) tick();
         if (f == 59) chk_frame("loop_replay", mk(0, 1, 0, 0, 11, 1));
         if (f == 60) loop_en = 1'b0;
         if (song_done && done_at == 0) done_at = f;
      end
      chk("loop_done_at", 32'(done_at), 32'd117);

      // end-of-song marker at entry 2
      do_reset();
      set_song(1, 1, 0, 1);
      start = 1'b1; tick(); start = 1'b0;
      done_at = 0; snd = 0; bad = 0;
      for (int f = 1; f <= 40; f++) begin
         if (f > 1) tick();
         if (!mute) snd++;
         if (!mute && mem_addr == 8'd2) bad++;
         if (song_done && done_at == 0) done_at = f;
      end
      chk("marker_done_at", 32'(done_at), 32'd25);
      chk("marker_sounded", 32'(snd), 32'd20);
      chk("marker_entry2_silent", 32'(bad), 32'd0);
      chk_frame("marker_idle", mk(1, 0, 0, 0, 22, 2));

      // pause mid-note and mid-gap
      do_reset();
      set_song(1, 1, 1, 1);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk_frame("pause_pre", mk(0, 1, 0, 0, 11, 1));
      pause = 1'b1;
      for (int j = 0; j < 7; j++) begin
         tick();
         chk_frame("pause_hold", mk(1, 1, 0, 0, 11, 1));
      end
      pause = 1'b0;
      snd = 0;
      for (int g = 0; g < 50; g++) begin
         tick();
         if (mute) break;
         snd++;
      end
      chk("pause_resume_cycles", 32'(snd), 32'd6);
      chk_frame("pause_gap_start", mk(1, 1, 0, 1, 11, 1));
      muted = 1;
      pause = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk_frame("pause_gap_hold", mk(1, 1, 0, 1, 11, 1));
         muted++;
      end
      pause = 1'b0;
      for (int g = 0; g < 50; g++) begin
         tick();
         if (!mute) break;
         muted++;
      end
      chk("pause_gap_len", 32'(muted), 32'd5);
      chk_frame("pause_after_gap", mk(0, 1, 0, 1, 22, 2));

      // stop mid-note, then start+stop together
      do_reset();
      set_song(1, 1, 1, 1);
      start = 1'b1; tick(); start = 1'b0;
      for (int f = 2; f <= 27; f++) tick();
      chk_frame("stop_pre", mk(0, 1, 0, 2, 0, 3));
      stop_req = 1'b1; tick(); stop_req = 1'b0;
      chk_frame("stop_post", mk(1, 0, 0, 0, 0, 3));
      start = 1'b1; stop_req = 1'b1; tick(); start = 1'b0; stop_req = 1'b0;
      chk_frame("start_stop_same", mk(1, 0, 0, 0, 0, 3));
      tick();
      chk_frame("start_stop_after", mk(1, 0, 0, 0, 0, 3));

      // async reset mid-gap, then start ignored while playing
      do_reset();
      set_song(1, 1, 1, 1);
      start = 1'b1; tick(); start = 1'b0;
      for (int f = 2; f <= 11; f++) tick();
      chk_frame("gap_before_reset", mk(1, 1, 0, 1, 11, 1));
      #2 rst_n = 1'b0;
      #1 chk_frame("async_reset", mk(1, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      snd = 0;
      for (int f = 1; f <= 40; f++) begin
         if (f > 1) begin
            start = (f == 4);
            tick();
            start = 1'b0;
         end
         if (!mute && mem_addr == 8'd0) snd++;
      end
      chk("start_ignored_len", 32'(snd), 32'd10);
      chk_frame("start_ignored_pos", mk(0, 1, 0, 3, 44, 4));

      // randomized songs and pauses against a frame-stream model
      for (int it = 0; it < 8; it++) begin
         do_reset();
         for (int i = 0; i < LEN; i++) begin
            s_dur[i]   = DW'($urandom_range(0, 4));
            s_note[i]  = 7'($urandom_range(0, 127));
            s_pitch[i] = 3'($urandom_range(0, 7));
         end
         if (it < 2) s_dur[0] = DW'(it * 3);
         loop_en = 1'($urandom_range(0, 1));
         q.delete();
         fin = 1'b0;
         ln = 7'd0; lp = 3'd0;
         if (s_dur[0] == '0) begin
            q.push_back(mk(1, 0, 1, 0, int'(ln), int'(lp)));
            fin = 1'b1;
         end else begin
            a = 0;
            while (q.size() < CAP) begin
               for (int k = 0; k < int'(s_dur[a]) * BEAT; k++)
                  q.push_back(mk(0, 1, 0, a, int'(s_note[a]), int'(s_pitch[a])));
               na = (a == LEN - 1) ? 0 : a + 1;
               for (int k = 0; k < GAP; k++)
                  q.push_back(mk(1, 1, 0, na, int'(s_note[a]), int'(s_pitch[a])));
               if (s_dur[na] == '0 || (na == 0 && !loop_en)) begin
                  q.push_back(mk(1, 0, 1, 0, int'(s_note[a]), int'(s_pitch[a])));
                  fin = 1'b1;
                  break;
               end
               a = na;
            end
         end
         start = 1'b1; tick(); start = 1'b0;
         idx = 0;
         chk_frame($sformatf("rand%0d_f0", it), q[0]);
         while (idx < q.size() - 1) begin
            if (!q[idx + 1].done && $urandom_range(0, 29) == 0) begin
               plen = $urandom_range(1, 5);
               pf = q[idx + 1];
               pf.mute = 1'b1;
               pause = 1'b1;
               for (int j = 0; j < plen; j++) begin
                  tick();
                  chk_frame($sformatf("rand%0d_pause_f%0d", it, idx), pf);
               end
               pause = 1'b0;
            end
            tick();
            idx++;
            chk_frame($sformatf("rand%0d_f%0d", it, idx), q[idx]);
         end
         if (!fin) begin
            stop_req = 1'b1; tick(); stop_req = 1'b0;
            pf = mk(1, 0, 0, 0, int'(q[idx].note), int'(q[idx].pitch));
            chk_frame($sformatf("rand%0d_stop", it), pf);
         end else begin
            pf = q[idx];
            pf.done = 1'b0;
            tick();
            chk_frame($sformatf("rand%0d_idle", it), pf);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
